// File: rtl/counter_pkg.sv
// Shared widths and types for the event-capture path that sits behind the free-running counter.
// Holds the timestamp type and the saturating helper used by the drop counter.
package counter_pkg;

    localparam int COUNT_W     = 32;
    localparam int EPOCH_W_DEF = 16;
    localparam int DROP_W      = 16;

    typedef logic [EPOCH_W_DEF+COUNT_W-1:0] timestamp_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous circular-buffer FIFO with extra-bit pointers, head always presented on rdata.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module capture_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 48,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    localparam int LW = AW + 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push, do_pop;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (level == LW'(DEPTH));
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/counter_event_capture.sv
// Timestamps rising edges of an asynchronous event line with {epoch, count} and queues them
// for a valid/ready reader; epoch counts upstream overflow rises.
module counter_event_capture
    import counter_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int EPOCH_W     = EPOCH_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [COUNT_W-1:0]         count,
    input  logic                       overflow,
    input  logic                       event_in,
    input  logic                       capture_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EPOCH_W+COUNT_W-1:0] out_timestamp,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [DROP_W-1:0]          drop_count,
    output logic [EPOCH_W-1:0]         epoch
);

    localparam int TS_W = EPOCH_W + COUNT_W;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_prev_q, sync_prev_d;
    logic                   ovf_q, ovf_d;
    logic [EPOCH_W-1:0]     epoch_q, epoch_d;
    logic [DROP_W-1:0]      drop_q, drop_d;

    logic                   sync_out, ev_rise, ovf_rise, push_req, pop;
    logic                   fifo_empty, fifo_full;
    logic [EPOCH_W-1:0]     eff_epoch;
    logic [TS_W-1:0]        entry;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign ev_rise  = sync_out & ~sync_prev_q;
    assign ovf_rise = overflow & ~ovf_q;
    // A capture landing on the wrap cycle belongs to the new epoch.
    assign eff_epoch = epoch_q + EPOCH_W'(ovf_rise);
    assign entry     = {eff_epoch, count};
    assign push_req  = ev_rise & capture_en;
    assign pop       = out_valid & out_ready;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], event_in};
        sync_prev_d = sync_out;
        ovf_d       = overflow;
        epoch_d     = eff_epoch;
        drop_d      = drop_q;
        if (push_req && fifo_full && !pop) drop_d = sat_inc(drop_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            ovf_q       <= 1'b0;
            epoch_q     <= '0;
            drop_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
            ovf_q       <= ovf_d;
            epoch_q     <= epoch_d;
            drop_q      <= drop_d;
        end
    end

    capture_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (entry),
        .pop   (pop),
        .rdata (out_timestamp),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fill_level)
    );

    assign out_valid  = ~fifo_empty;
    assign drop_count = drop_q;
    assign epoch      = epoch_q;

endmodule

// File: tb/tb_counter_event_capture.sv
// Scoreboard bench for counter_event_capture: expected timestamps are queued when an event is
// driven and compared as the reader pops them.
module tb_counter_event_capture;
    import counter_pkg::*;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;

    logic        clk = 0;
    logic        reset = 1;
    logic [31:0] count = 0;
    logic        overflow = 0;
    logic        event_in = 0;
    logic        capture_en = 1;
    logic        out_valid;
    logic        out_ready = 0;
    timestamp_t  out_timestamp;
    logic [3:0]  fill_level;
    logic [15:0] drop_count;
    logic [15:0] epoch;

    counter_event_capture #(.DEPTH(DEPTH), .EPOCH_W(16), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .reset         (reset),
        .count         (count),
        .overflow      (overflow),
        .event_in      (event_in),
        .capture_en    (capture_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_timestamp (out_timestamp),
        .fill_level    (fill_level),
        .drop_count    (drop_count),
        .epoch         (epoch)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    timestamp_t  sb[$];
    int          mfill = 0;
    logic [15:0] mdrop = 0;
    logic [15:0] mepoch = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_fill"},  64'(fill_level), 64'(mfill));
        chk({tag, "_drop"},  64'(drop_count), 64'(mdrop));
        chk({tag, "_epoch"}, 64'(epoch),      64'(mepoch));
    endtask

    // Event held 4 cycles with count steady; the push lands on the third edge.
    task automatic fire(input logic [31:0] v);
        count    = v;
        event_in = 1;
        tick(); tick(); tick();
        if (capture_en) begin
            if (mfill < DEPTH) begin
                sb.push_back({mepoch, v});
                mfill++;
            end else if (mdrop != 16'hFFFF) begin
                mdrop++;
            end
        end
        tick();
        event_in = 0;
        tick(); tick(); tick();
    endtask

    task automatic drain_n(input int n);
        timestamp_t exp;
        out_ready = 1;
        for (int i = 0; i < n; i++) begin
            if (!out_valid || sb.size() == 0) begin
                chk("drain_avail", {63'd0, out_valid}, {63'd0, sb.size() != 0});
                break;
            end
            exp = sb.pop_front();
            chk("head_ts", 64'(out_timestamp), 64'(exp));
            tick();
            mfill--;
        end
        out_ready = 0;
    endtask

    task automatic drain_all(input string tag);
        drain_n(sb.size());
        chk({tag, "_empty_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_empty_ts"},  64'(out_timestamp), 64'd0);
        chk({tag, "_empty_fill"}, 64'(fill_level), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1;
        tick(); tick();
        reset = 0;
        sb.delete();
        mfill = 0; mdrop = 0; mepoch = 0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_ts",  64'(out_timestamp), 64'd0);
        chk_state("rst");

        // single event: latency and head value, stable while not ready
        count    = 32'h10;
        event_in = 1;
        tick(); tick();
        chk("lat_vld_early", 64'(out_valid), 64'd0);
        tick();
        chk("lat_vld", 64'(out_valid), 64'd1);
        sb.push_back({16'h0, 32'h10});
        mfill = 1;
        chk("lat_ts", 64'(out_timestamp), {16'h0, 16'h0, 32'h10});
        tick();
        event_in = 0;
        tick(); tick(); tick();
        chk("hold_ts", 64'(out_timestamp), {16'h0, 16'h0, 32'h10});
        chk_state("single");
        drain_all("single");

        // wrap: push on the same cycle overflow rises records the new epoch
        count    = 32'hFFFF_FFFF;
        event_in = 1;
        tick(); tick();
        count    = 32'h0;
        overflow = 1;
        tick();
        mepoch = 1;
        sb.push_back({16'h1, 32'h0});
        mfill = 1;
        event_in = 0;
        for (int i = 0; i < 9; i++) tick();
        chk_state("wrap_hold");
        overflow = 0;
        tick(); tick(); tick();
        drain_all("wrap");

        // fill past depth: one drop, then in-order drain
        for (int i = 0; i < 9; i++) fire(32'h100 + 32'(i));
        chk_state("fill");
        drain_all("fill");

        // full with a pop on the push cycle: level and drop count unchanged
        for (int i = 0; i < 8; i++) fire(32'h200 + 32'(i));
        chk_state("refill");
        count    = 32'h2FF;
        event_in = 1;
        tick(); tick();
        out_ready = 1;
        chk("fp_head", 64'(out_timestamp), 64'(sb[0]));
        void'(sb.pop_front());
        sb.push_back({mepoch, 32'h2FF});
        tick();
        out_ready = 0;
        chk_state("full_pop");
        tick();
        event_in = 0;
        tick(); tick(); tick();
        drain_all("full_pop");

        // capture disabled: edges ignored, epoch still tracks
        do_reset();
        capture_en = 0;
        for (int i = 0; i < 3; i++) fire(32'h300 + 32'(i));
        for (int i = 0; i < 2; i++) begin
            overflow = 1; tick();
            overflow = 0; tick();
            mepoch++;
        end
        chk_state("cap_off");
        chk("cap_off_vld", 64'(out_valid), 64'd0);
        capture_en = 1;

        // reset mid-operation
        overflow = 1; tick();
        overflow = 0; tick();
        mepoch++;
        for (int i = 0; i < 10; i++) fire(32'h400 + 32'(i));
        drain_n(3);
        chk_state("pre_rst");
        reset = 1;
        tick();
        reset = 0;
        sb.delete();
        mfill = 0; mdrop = 0; mepoch = 0;
        chk("mid_rst_vld", 64'(out_valid), 64'd0);
        chk("mid_rst_ts",  64'(out_timestamp), 64'd0);
        chk_state("mid_rst");
        fire(32'h55);
        chk("post_rst_ts", 64'(out_timestamp), {16'h0, 16'h0, 32'h55});
        drain_all("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
